// File: rtl/qam_pkg.sv
// Shared QAM definitions: mode encodings, bits-per-symbol helper and word width.
package qam_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    QAM_2  = 3'd0,
    QAM_4  = 3'd1,
    QAM_16 = 3'd2
  } qam_mode_e;

  typedef enum logic {
    OUT_IDLE,
    OUT_HOLD
  } out_state_e;

  // Zero marks an illegal mode.
  function automatic logic [2:0] bps(input logic [2:0] mode);
    case (mode)
      QAM_2:   return 3'd1;
      QAM_4:   return 3'd2;
      QAM_16:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/qam_demod_if.sv
// Symbol-in / word-out handshake bundle of the QAM demodulator.
interface qam_demod_if;
  logic [2:0]  qam;
  logic [31:0] sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic        sync;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        error;

  modport master (
    output qam, sym_in, sym_valid, sync, word_ready,
    input  sym_ready, word_out, word_valid, error
  );

  modport slave (
    input  qam, sym_in, sym_valid, sync, word_ready,
    output sym_ready, word_out, word_valid, error
  );
endinterface

// File: rtl/qam_slicer.sv
// Hard-decision slicer: maps one {I,Q} symbol to 1/2/4 bits; unused upper bits are zero.
module qam_slicer
  import qam_pkg::*;
#(
  parameter int unsigned        W      = 16,
  parameter logic signed [15:0] THRESH = 16'sd8192
) (
  input  logic [2*W-1:0] sym_in,
  input  logic [2:0]     mode,
  output logic [3:0]     bits
);

  // Magnitude in W+1 bits so the most negative input does not wrap.
  function automatic logic [W:0] mag(input logic [W-1:0] x);
    logic [W:0] e;
    e = {x[W-1], x};
    return e[W] ? ('0 - e) : e;
  endfunction

  logic [W-1:0] i_c, q_c;
  logic         s_i, s_q, in_i, in_q;
  logic [W:0]   thr;

  assign i_c  = sym_in[2*W-1:W];
  assign q_c  = sym_in[W-1:0];
  assign thr  = (W+1)'($unsigned(THRESH));
  assign s_i  = ~i_c[W-1];
  assign s_q  = ~q_c[W-1];
  assign in_i = mag(i_c) < thr;
  assign in_q = mag(q_c) < thr;

  always_comb begin
    bits = '0;
    case (mode)
      QAM_2:   bits = {3'b000, s_i};
      QAM_4:   bits = {2'b00, s_q, s_i};
      QAM_16:  bits = {in_q, s_q, in_i, s_i};
      default: bits = '0;
    endcase
  end

endmodule

// File: rtl/qam_demod_top.sv
// QAM receive packer: slices symbols and packs bits LSB-first into 32-bit words.
module qam_demod_top
  import qam_pkg::*;
#(
  parameter logic signed [15:0] THRESH = 16'sd8192,
  parameter int unsigned        W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  qam_demod_if.slave  bus
);

  logic [5:0]        bit_cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] word_q;
  logic [2:0]        mode_lat;
  logic              error_q;
  out_state_e        state, state_nx;

  logic              start, completes, sym_acc, word_acc, word_valid;
  logic [2:0]        eff_mode, eff_bps;
  logic [5:0]        base;
  logic [6:0]        nxt_sum;
  logic [3:0]        bits;
  logic [WORD_W-1:0] merged;

  qam_slicer #(.W(W), .THRESH(THRESH)) u_slicer (
    .sym_in (bus.sym_in),
    .mode   (eff_mode),
    .bits   (bits)
  );

  // A word boundary or sync both restart packing at bit 0 with a fresh mode sample.
  assign start     = (bit_cnt == '0) || bus.sync;
  assign eff_mode  = start ? bus.qam : mode_lat;
  assign eff_bps   = bps(eff_mode);
  assign base      = start ? '0 : bit_cnt;
  assign nxt_sum   = {1'b0, base} + 7'(eff_bps);
  assign completes = (eff_bps != '0) && (nxt_sum == 7'(WORD_W));
  assign merged    = (start ? '0 : acc) | (WORD_W'(bits) << base);

  assign word_valid    = (state == OUT_HOLD);
  assign bus.sym_ready = ~(word_valid & ~bus.word_ready & completes);
  assign sym_acc       = bus.sym_valid & bus.sym_ready;
  assign word_acc      = word_valid & bus.word_ready;

  assign bus.word_valid = word_valid;
  assign bus.word_out   = word_q;
  assign bus.error      = error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OUT_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      OUT_IDLE: if (sym_acc && completes) state_nx = OUT_HOLD;
      OUT_HOLD: if (word_acc && !(sym_acc && completes)) state_nx = OUT_IDLE;
      default:  state_nx = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      acc      <= '0;
      word_q   <= '0;
      mode_lat <= '0;
      error_q  <= 1'b0;
    end else if (sym_acc) begin
      if (start) mode_lat <= bus.qam;
      if (eff_bps == '0) begin
        error_q <= 1'b1;
        bit_cnt <= '0;
        acc     <= '0;
      end else if (completes) begin
        word_q  <= merged;
        bit_cnt <= '0;
        acc     <= '0;
      end else begin
        acc     <= merged;
        bit_cnt <= nxt_sum[5:0];
      end
    end
  end

endmodule

// File: tb/tb_qam_demod_top.sv
// Directed bench for qam_demod_top with a bit-queue reference model checked every cycle.
module tb_qam_demod_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  qam_demod_if bus();

  qam_demod_top #(.THRESH(16'sd8192), .W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mq[$];
  int          m_mode  = 0;
  bit          m_valid = 0;
  logic [31:0] m_word  = '0;
  bit          m_err   = 0;
  logic [31:0] m_words[$];

  function automatic int bps_of(input int md);
    case (md)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int slice(input int md, input logic [31:0] s);
    int i, q;
    bit si, sq, ii, iq;
    i  = int'($signed(s[31:16]));
    q  = int'($signed(s[15:0]));
    si = (i >= 0);
    sq = (q >= 0);
    ii = (((i < 0) ? -i : i) < 8192);
    iq = (((q < 0) ? -q : q) < 8192);
    case (md)
      0: return int'(si);
      1: return int'(si) + 2 * int'(sq);
      2: return int'(si) + 2 * int'(ii) + 4 * int'(sq) + 8 * int'(iq);
      default: return 0;
    endcase
  endfunction

  function automatic bit m_ready();
    bit st;
    int md, n, b;
    st = (mq.size() == 0) || bus.sync;
    md = st ? int'(bus.qam) : m_mode;
    n  = bps_of(md);
    b  = st ? 0 : mq.size();
    return !(m_valid && !bus.word_ready && n != 0 && b + n == 32);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_mode = 0; m_valid = 0; m_word = '0; m_err = 0;
      end else begin
        bit rdy, nv, st;
        int md, n, v;
        logic [31:0] w;
        rdy = m_ready();
        nv  = m_valid && !bus.word_ready;
        if (bus.sym_valid && rdy) begin
          st = (mq.size() == 0) || bus.sync;
          if (st) begin
            mq.delete();
            m_mode = int'(bus.qam);
          end
          md = m_mode;
          n  = bps_of(md);
          if (n == 0) begin
            m_err = 1;
            mq.delete();
          end else begin
            v = slice(md, bus.sym_in);
            for (int k = 0; k < n; k++) mq.push_back(bit'((v >> k) & 1));
            if (mq.size() == 32) begin
              w = '0;
              for (int k = 0; k < 32; k++) if (mq[k]) w = w + (32'd1 << k);
              m_word = w;
              m_words.push_back(w);
              nv = 1;
              mq.delete();
            end
          end
        end
        m_valid = nv;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) vcount++;
    if (!rst) begin
      chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
      chk("rst_word_out", bus.word_out, 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
    end else begin
      chk("sym_ready", 32'(bus.sym_ready), 32'(m_ready()));
      chk("word_valid", 32'(bus.word_valid), 32'(m_valid));
      if (m_valid) chk("word_out", bus.word_out, m_word);
      chk("error", 32'(bus.error), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] m, input int i, input int q, input bit sy);
    int  t;
    bit  r;
    logic [15:0] iv, qv;
    t  = 0;
    iv = 16'(i);
    qv = 16'(q);
    bus.qam       = m;
    bus.sym_in    = {iv, qv};
    bus.sym_valid = 1'b1;
    bus.sync      = sy;
    forever begin
      @(negedge clk);
      r = bus.sym_ready;
      @(posedge clk);
      #1;
      if (r) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.sym_valid = 1'b0;
    bus.sync      = 1'b0;
  endtask

  task automatic word_chk(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, 32'(bus.word_valid), 32'd1);
    chk({name, "_dut"}, bus.word_out, exp);
    if (m_words.size() == 0) chk({name, "_model_empty"}, 32'd1, 32'd0);
    else chk({name, "_model"}, m_words.pop_front(), exp);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.qam = '0; bus.sym_in = '0; bus.sym_valid = 1'b0;
    bus.sync = 1'b0; bus.word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1: 2-QAM alternating sign
    vcount = 0;
    for (int k = 0; k < 32; k++) send(3'd0, (k % 2 == 0) ? 100 : -100, 0, 1'b0);
    word_chk("t1", 32'h5555_5555);
    repeat (3) @(posedge clk);
    #1 chk("t1_valid_cycles", 32'(vcount), 32'd1);

    // 2: 4-QAM two words
    for (int k = 0; k < 16; k++) send(3'd1, -5, 5, 1'b0);
    word_chk("t2a", 32'hAAAA_AAAA);
    for (int k = 0; k < 16; k++) send(3'd1, 5, -5, 1'b0);
    word_chk("t2b", 32'h5555_5555);

    // 3: 16-QAM thresholds and full-scale negative
    for (int k = 0; k < 8; k++) send(3'd2, 3000, -20000, 1'b0);
    word_chk("t3a", 32'h3333_3333);
    for (int k = 0; k < 8; k++) send(3'd2, -32768, 1, 1'b0);
    word_chk("t3b", 32'hCCCC_CCCC);

    // 4: backpressure on the completing symbol
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(3'd1, 5, 5, 1'b0);
    word_chk("t4a", 32'hFFFF_FFFF);
    for (int k = 0; k < 15; k++) send(3'd1, -5, 5, 1'b0);
    bus.qam = 3'd1; bus.sym_in = {16'hFFFB, 16'h0005}; bus.sym_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t4_stall", 32'(bus.sym_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.word_ready = 1'b1;
    @(negedge clk);
    chk("t4_release", 32'(bus.sym_ready), 32'd1);
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    word_chk("t4b", 32'hAAAA_AAAA);
    @(posedge clk); #1;
    chk("t4_drain", 32'(bus.word_valid), 32'd0);

    // 5: mid-word mode change ignored, then sync restart
    for (int k = 0; k < 16; k++) send((k < 3) ? 3'd1 : 3'd0, 5, -5, 1'b0);
    word_chk("t5a", 32'h5555_5555);
    for (int k = 0; k < 4; k++) send(3'd0, -100, 0, 1'b0);
    send(3'd0, 100, 0, 1'b1);
    for (int k = 0; k < 31; k++) send(3'd0, -100, 0, 1'b0);
    word_chk("t5b", 32'h0000_0001);

    // 6: illegal mode, then asynchronous reset mid-word
    for (int k = 0; k < 3; k++) send(3'd5, 100, 100, 1'b0);
    chk("t6_error", 32'(bus.error), 32'd1);
    chk("t6_no_word", 32'(bus.word_valid), 32'd0);
    bus.word_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(3'd1, 5, 5, 1'b0);
    word_chk("t6a", 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) send(3'd1, 5, 5, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.word_valid), 32'd0);
    chk("t6_async_word", bus.word_out, 32'd0);
    chk("t6_async_error", 32'(bus.error), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.word_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(3'd2, 3000, -20000, 1'b0);
    word_chk("t6b", 32'h3333_3333);
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
